// File: rtl/truth_sweep_ctrl_if.sv
// Control/result bundle and vector bus of the truth-table sweeper.
// SWEEP_ABORT_ON_FAIL_EN adds the fail_idx signal.
interface truth_sweep_ctrl_if;
    logic        start;
    logic [15:0] expected;
    logic        q;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic [4:0]  mismatch_cnt;
    logic        pass;
`ifdef SWEEP_ABORT_ON_FAIL_EN
    logic [3:0]  fail_idx;

    modport master (
        output start, expected, q,
        input  a, b, c, d, busy, done,
        input  table_out, mismatch_cnt, pass, fail_idx
    );

    modport slave (
        input  start, expected, q,
        output a, b, c, d, busy, done,
        output table_out, mismatch_cnt, pass, fail_idx
    );
`else
    modport master (
        output start, expected, q,
        input  a, b, c, d, busy, done,
        input  table_out, mismatch_cnt, pass
    );

    modport slave (
        input  start, expected, q,
        output a, b, c, d, busy, done,
        output table_out, mismatch_cnt, pass
    );
`endif
endinterface

// File: rtl/truth_sweep_ctrl.sv
// Drives all 16 vectors of a 4-input function and checks its truth table.
// SWEEP_ABORT_ON_FAIL_EN stops at the first mismatch and reports fail_idx.
module truth_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    truth_sweep_ctrl_if.slave sw
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

    localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

    state_e      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  cnt_q;
    logic [15:0] exp_q;
    logic [15:0] table_q;
    logic [15:0] table_d;
    logic [4:0]  mis_q;
    logic [4:0]  mis_d;
    logic        miss;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
`ifdef SWEEP_ABORT_ON_FAIL_EN
    logic [3:0]  fail_idx_q;
`endif

    assign miss  = sw.q != exp_q[idx_q];
    assign mis_d = mis_q + {4'd0, miss};

    always_comb begin
        table_d        = table_q;
        table_d[idx_q] = sw.q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            exp_q      <= '0;
            table_q    <= '0;
            mis_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
`ifdef SWEEP_ABORT_ON_FAIL_EN
            fail_idx_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (sw.start) begin
                        exp_q      <= sw.expected;
                        table_q    <= '0;
                        mis_q      <= '0;
                        pass_q     <= 1'b0;
                        idx_q      <= '0;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
`ifdef SWEEP_ABORT_ON_FAIL_EN
                        fail_idx_q <= '0;
`endif
                        state_q    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == LAST) begin
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                SAMPLE: begin
                    table_q <= table_d;
                    mis_q   <= mis_d;
`ifdef SWEEP_ABORT_ON_FAIL_EN
                    if (miss || idx_q == 4'd15) begin
                        if (miss) begin
                            fail_idx_q <= idx_q;
                        end
`else
                    if (idx_q == 4'd15) begin
`endif
                        // idx returns to 0 so the vector bus idles low in DONE
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= mis_d == 5'd0;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + 4'd1;
                        cnt_q   <= '0;
                        state_q <= SETTLE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sw.a            = idx_q[3];
    assign sw.b            = idx_q[2];
    assign sw.c            = idx_q[1];
    assign sw.d            = idx_q[0];
    assign sw.busy         = busy_q;
    assign sw.done         = done_q;
    assign sw.table_out    = table_q;
    assign sw.mismatch_cnt = mis_q;
    assign sw.pass         = pass_q;
`ifdef SWEEP_ABORT_ON_FAIL_EN
    assign sw.fail_idx     = fail_idx_q;
`endif
endmodule
